hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_unit.sv | 113 +++++++++++
 tb/tb_hilo_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO architectural register pair with multiply-pending tracking.
// Latency: hi_q/lo_q update at the edge of mul_valid or an accepted MT write;
//   mf_data/mf_ready/issue_ready/mt_ready are combinational (0 cycles).
// Backpressure: issue_ready drops at MAX_INFLIGHT outstanding multiplies;
//   mt_ready and mf_ready stall until the pipeline drains (mf may bypass the
//   final result in its completion cycle).
// Ports:
//   clk, reset (async, active-low), flush (sync pipeline flush)
//   mul_issue/issue_ready      - multiply issue handshake
//   mul_valid, mul_hi, mul_lo  - multiply result from the MUL pipeline
//   mt_we, mt_sel, mt_data / mt_ready - MTHI/MTLO write handshake
//   mf_req, mf_sel / mf_data, mf_ready - MFHI/MFLO read handshake
//   hi_q, lo_q                 - architectural HI/LO contents
//   pend_err                   - sticky flag: result arrived with nothing pending
module hilo_unit #(
  parameter int MAX_INFLIGHT = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        mul_issue,
  output logic        issue_ready,
  input  logic        mul_valid,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic [31:0] mt_data,
  output logic        mt_ready,
  input  logic        mf_req,
  input  logic        mf_sel,
  output logic [31:0] mf_data,
  output logic        mf_ready,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic        pend_err
);

  localparam logic [2:0] MaxPend = 3'(MAX_INFLIGHT);

  logic [2:0]  pend_q, pend_d;
  logic [31:0] hi_d, lo_d;
  logic        pend_err_q, pend_err_d;
  logic        issue_acc;
  logic        stray_vld;
  logic        pend_zero;

  assign pend_zero   = (pend_q == 3'd0);
  assign issue_ready = (pend_q < MaxPend);
  assign issue_acc   = mul_issue & issue_ready;
  // A result with nothing outstanding (and no issue this cycle to pair with)
  // is a protocol error from the MUL side; it must not touch HI/LO.
  assign stray_vld   = mul_valid & pend_zero & ~issue_acc;

  // Handshake outputs are forced to their idle values while reset is held,
  // even though mul_valid/mf_req may be toggling upstream.
  assign mt_ready = ~reset | (pend_zero & ~mul_valid);
  assign mf_ready = reset & mf_req & (pend_zero | ((pend_q == 3'd1) & mul_valid));

  // The completing result is forwarded in the same cycle it lands so a
  // dependent MFHI/MFLO does not lose a cycle waiting for the register write.
  always_comb begin
    mf_data = 32'h0;
    if (mf_ready) begin
      if (mul_valid) mf_data = mf_sel ? mul_hi : mul_lo;
      else           mf_data = mf_sel ? hi_q   : lo_q;
    end
  end

  always_comb begin
    pend_d     = pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_err_d = pend_err_q;
    if (flush) begin
      // Everything in flight is dropped; HI/LO keep their committed values.
      pend_d = 3'd0;
    end else begin
      if (issue_acc && !mul_valid) begin
        pend_d = pend_q + 3'd1;
      end else if (mul_valid && !issue_acc && !pend_zero) begin
        pend_d = pend_q - 3'd1;
      end
      if (mul_valid && !stray_vld) begin
        hi_d = mul_hi;
        lo_d = mul_lo;
      end
      if (stray_vld) pend_err_d = 1'b1;
      // mt_ready excludes mul_valid, so this never collides with a result write.
      if (mt_we && mt_ready) begin
        if (mt_sel) hi_d = mt_data;
        else        lo_d = mt_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q     <= 3'd0;
      hi_q       <= 32'h0;
      lo_q       <= 32'h0;
      pend_err_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_err_q <= pend_err_d;
    end
  end

  assign pend_err = pend_err_q;

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        mul_issue;
  logic        issue_ready;
  logic        mul_valid;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic        mt_we;
  logic        mt_sel;
  logic [31:0] mt_data;
  logic        mt_ready;
  logic        mf_req;
  logic        mf_sel;
  logic [31:0] mf_data;
  logic        mf_ready;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        pend_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  hilo_unit #(.MAX_INFLIGHT(6)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .mul_issue(mul_issue), .issue_ready(issue_ready),
    .mul_valid(mul_valid), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data), .mt_ready(mt_ready),
    .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data), .mf_ready(mf_ready),
    .hi_q(hi_q), .lo_q(lo_q), .pend_err(pend_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read monitor: every presented read result is matched against the queue.
  always @(negedge clk) begin
    if (mf_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mf_unexpected: got mf_data %h with no read expected", mf_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (mf_data !== e) begin
          errors++;
          $display("FAIL mf_data: got %h expected %h", mf_data, e);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    flush = 0; mul_issue = 0; mul_valid = 0; mul_hi = 0; mul_lo = 0;
    mt_we = 0; mt_sel = 0; mt_data = 0; mf_req = 0; mf_sel = 0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_in();
    reset = 0;
    // Upstream activity during reset must not leak through the handshakes.
    mul_valid = 1; mul_hi = 32'hAAAA_AAAA; mf_req = 1; mf_sel = 1;
    #2;
    chk("rst_hi", hi_q, 32'h0);
    chk("rst_lo", lo_q, 32'h0);
    chk("rst_err", {31'b0, pend_err}, 32'h0);
    chk("rst_issue_rdy", {31'b0, issue_ready}, 32'h1);
    chk("rst_mt_rdy", {31'b0, mt_ready}, 32'h1);
    chk("rst_mf_rdy", {31'b0, mf_ready}, 32'h0);
    chk("rst_mf_data", mf_data, 32'h0);
    nxt();
    chk("rst_hi_after_edge", hi_q, 32'h0);
    #3;
    reset = 1;
    idle_in();
    nxt();

    // Basic multiply: result lands 6 cycles after issue.
    mul_issue = 1;
    @(negedge clk);
    chk("t1_issue_rdy", {31'b0, issue_ready}, 32'h1);
    nxt();
    mul_issue = 0;
    @(negedge clk);
    chk("t1_mt_stall", {31'b0, mt_ready}, 32'h0);
    repeat (5) nxt();
    mul_valid = 1; mul_hi = 32'h1; mul_lo = 32'hFFFF_FFFE;
    nxt();
    idle_in();
    chk("t1_hi", hi_q, 32'h1);
    chk("t1_lo", lo_q, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("t1_pend0", {31'b0, mt_ready}, 32'h1);
    nxt();

    // Read stall then bypass on the completion cycle.
    mul_issue = 1;
    nxt();
    mul_issue = 0; mf_req = 1; mf_sel = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_mf_stall", {31'b0, mf_ready}, 32'h0);
      chk("t2_mf_data0", mf_data, 32'h0);
      nxt();
    end
    mul_valid = 1; mul_hi = 32'h1234_5678; mul_lo = 32'h9ABC_DEF0;
    exp_q.push_back(32'h1234_5678);
    @(negedge clk);
    chk("t2_mf_bypass_rdy", {31'b0, mf_ready}, 32'h1);
    nxt();
    // Same-cycle read and write: read sees the pre-write value.
    mul_valid = 0; mf_sel = 0; mt_we = 1; mt_sel = 0; mt_data = 32'h0000_0055;
    exp_q.push_back(32'h9ABC_DEF0);
    nxt();
    mt_we = 0;
    exp_q.push_back(32'h0000_0055);
    nxt();
    idle_in();
    chk("t2_hi", hi_q, 32'h1234_5678);
    chk("t2_lo", lo_q, 32'h0000_0055);

    // Saturation at MAX_INFLIGHT.
    for (int i = 0; i < 7; i++) begin
      mul_issue = 1;
      @(negedge clk);
      chk($sformatf("t3_issue_rdy%0d", i), {31'b0, issue_ready}, (i < 6) ? 32'h1 : 32'h0);
      nxt();
    end
    mul_issue = 1; mul_valid = 1; mul_hi = 32'hA; mul_lo = 32'hB;
    @(negedge clk);
    chk("t3_full_rdy", {31'b0, issue_ready}, 32'h0);
    nxt();
    idle_in();
    @(negedge clk);
    chk("t3_pend5_rdy", {31'b0, issue_ready}, 32'h1);
    chk("t3_hi", hi_q, 32'hA);
    for (int i = 0; i < 4; i++) begin
      mul_valid = 1; mul_hi = 32'h100 + 32'(i); mul_lo = 32'h200 + 32'(i);
      nxt();
    end
    idle_in();
    @(negedge clk);
    chk("t3_pend1_mt", {31'b0, mt_ready}, 32'h0);
    mul_valid = 1; mul_hi = 32'h7; mul_lo = 32'h8;
    nxt();
    idle_in();
    @(negedge clk);
    chk("t3_pend0_mt", {31'b0, mt_ready}, 32'h1);
    chk("t3_no_err", {31'b0, pend_err}, 32'h0);
    nxt();

    // MT write waits for the outstanding multiply.
    mul_issue = 1;
    nxt();
    mul_issue = 0; mt_we = 1; mt_sel = 0; mt_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t4_mt_stall", {31'b0, mt_ready}, 32'h0);
    nxt();
    mul_valid = 1; mul_hi = 32'h0000_0C0D; mul_lo = 32'h0000_0E0F;
    @(negedge clk);
    chk("t4_mt_stall_vld", {31'b0, mt_ready}, 32'h0);
    nxt();
    mul_valid = 0;
    @(negedge clk);
    chk("t4_mt_acc", {31'b0, mt_ready}, 32'h1);
    nxt();
    idle_in();
    chk("t4_lo", lo_q, 32'hDEAD_BEEF);
    chk("t4_hi", hi_q, 32'h0000_0C0D);

    // Flush, discard, stray result and sticky error.
    mul_issue = 1;
    repeat (3) nxt();
    mul_issue = 0; flush = 1;
    nxt();
    flush = 0;
    @(negedge clk);
    chk("t5_flush_pend0", {31'b0, mt_ready}, 32'h1);
    flush = 1; mul_issue = 1; mt_we = 1; mt_sel = 1; mt_data = 32'h1111_1111;
    nxt();
    idle_in();
    chk("t5_flush_mt_drop", hi_q, 32'h0000_0C0D);
    @(negedge clk);
    chk("t5_flush_issue_drop", {31'b0, mt_ready}, 32'h1);
    mul_valid = 1; mul_hi = 32'hEE; mul_lo = 32'hFF;
    nxt();
    idle_in();
    chk("t5_stray_hi", hi_q, 32'h0000_0C0D);
    chk("t5_stray_lo", lo_q, 32'hDEAD_BEEF);
    chk("t5_err", {31'b0, pend_err}, 32'h1);
    flush = 1;
    nxt();
    flush = 0;
    chk("t5_err_sticky", {31'b0, pend_err}, 32'h1);

    // Asynchronous reset between edges with two multiplies outstanding.
    mul_issue = 1;
    repeat (2) nxt();
    mul_issue = 0;
    #2;
    reset = 0;
    #1;
    chk("t6_hi", hi_q, 32'h0);
    chk("t6_lo", lo_q, 32'h0);
    chk("t6_err", {31'b0, pend_err}, 32'h0);
    chk("t6_issue_rdy", {31'b0, issue_ready}, 32'h1);
    chk("t6_mt_rdy", {31'b0, mt_ready}, 32'h1);
    nxt();
    #2;
    reset = 1;
    mul_valid = 1; mul_hi = 32'h33; mul_lo = 32'h44;
    nxt();
    idle_in();
    chk("t6_forgot_err", {31'b0, pend_err}, 32'h1);
    chk("t6_forgot_hi", hi_q, 32'h0);
    nxt();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mf_missing: got %0d reads outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
